// File: rtl/rs_fu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rs_fu_issue_arbiter
// Brief    : Matches ready reservation-station entries to free functional
//            units, up to an issue limit, with registered dispatch outputs.
// Revision : 1.0 - initial release
// ============================================================================
module rs_fu_issue_arbiter #(
    parameter int NUM_OF_RS      = 8,
    parameter int NUM_OF_FU      = 4,
    parameter int ISSUE_WIDTH    = 2,
    parameter int FU_BUSY_CYCLES = 0,
    parameter int ARB_MODE       = 1,
    localparam int FU_IDX_WIDTH  = (NUM_OF_FU > 1) ? $clog2(NUM_OF_FU) : 1,
    localparam int RS_IDX_WIDTH  = (NUM_OF_RS > 1) ? $clog2(NUM_OF_RS) : 1,
    localparam int BUSY_WIDTH    = (FU_BUSY_CYCLES > 0) ? $clog2(FU_BUSY_CYCLES + 1) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    input  logic [NUM_OF_RS-1:0]                     rs_ready,
    input  logic [NUM_OF_FU-1:0]                     fu_ready,
    output logic [NUM_OF_RS-1:0]                     rs_dispatch_en,
    output logic [NUM_OF_RS-1:0][FU_IDX_WIDTH-1:0]   rs_fu_assign,
    output logic [NUM_OF_FU-1:0]                     fu_issue_valid,
    output logic [NUM_OF_FU-1:0][RS_IDX_WIDTH-1:0]   fu_issue_rs_idx,
    output logic [NUM_OF_FU-1:0]                     fu_busy,
    output logic [15:0]                              stall_cycles
);

    localparam int c_LIMIT_RS = (ISSUE_WIDTH < NUM_OF_RS) ? ISSUE_WIDTH : NUM_OF_RS;
    localparam int c_LIMIT    = (c_LIMIT_RS < NUM_OF_FU) ? c_LIMIT_RS : NUM_OF_FU;

    logic [RS_IDX_WIDTH-1:0]                    r_rr_ptr;
    logic [NUM_OF_FU-1:0][BUSY_WIDTH-1:0]       r_busy_cnt;
    logic [15:0]                                r_stall_cycles;

    logic [NUM_OF_RS-1:0]                       w_eligible;
    logic [NUM_OF_FU-1:0]                       w_fu_avail;
    logic [NUM_OF_FU-1:0]                       w_fu_taken;
    logic [NUM_OF_RS-1:0]                       w_grant_rs;
    logic [NUM_OF_RS-1:0][FU_IDX_WIDTH-1:0]     w_grant_assign;
    logic [NUM_OF_FU-1:0]                       w_grant_fu;
    logic [NUM_OF_FU-1:0][RS_IDX_WIDTH-1:0]     w_grant_src;
    logic [RS_IDX_WIDTH-1:0]                    w_last_idx;
    logic [RS_IDX_WIDTH-1:0]                    w_scan_ptr;
    logic [FU_IDX_WIDTH-1:0]                    w_sel_fu;
    logic                                       w_found;
    logic                                       w_any_grant;
    logic                                       w_stall;
    int                                         w_scan_idx;
    int                                         w_grant_cnt;

    // Entries already dispatched last cycle are masked while the RS retires them.
    assign w_eligible  = rs_ready & ~rs_dispatch_en;
    assign w_any_grant = |w_grant_rs;
    assign w_stall     = (|w_eligible) && !w_any_grant && !flush;

    generate
        for (genvar f = 0; f < NUM_OF_FU; f++) begin : g_fu_status
            assign w_fu_avail[f] = fu_ready[f] && (r_busy_cnt[f] == '0);
            assign fu_busy[f]    = (r_busy_cnt[f] != '0);
        end
    endgenerate

    always_comb begin
        w_fu_taken     = '0;
        w_grant_rs     = '0;
        w_grant_assign = '0;
        w_grant_fu     = '0;
        w_grant_src    = '0;
        w_last_idx     = r_rr_ptr;
        w_grant_cnt    = 0;
        w_scan_idx     = 0;
        w_scan_ptr     = '0;
        w_found        = 1'b0;
        w_sel_fu       = '0;
        for (int k = 0; k < NUM_OF_RS; k++) begin
            w_scan_idx = int'(r_rr_ptr) + k;
            if (w_scan_idx >= NUM_OF_RS) begin
                w_scan_idx = w_scan_idx - NUM_OF_RS;
            end
            w_scan_ptr = RS_IDX_WIDTH'(w_scan_idx);
            // Descending search leaves the lowest-index free FU selected.
            w_found  = 1'b0;
            w_sel_fu = '0;
            for (int f = NUM_OF_FU - 1; f >= 0; f--) begin
                if (w_fu_avail[f] && !w_fu_taken[f]) begin
                    w_found  = 1'b1;
                    w_sel_fu = FU_IDX_WIDTH'(f);
                end
            end
            if (w_eligible[w_scan_ptr] && w_found && (w_grant_cnt < c_LIMIT)) begin
                w_fu_taken[w_sel_fu]       = 1'b1;
                w_grant_rs[w_scan_ptr]     = 1'b1;
                w_grant_assign[w_scan_ptr] = w_sel_fu;
                w_grant_fu[w_sel_fu]       = 1'b1;
                w_grant_src[w_sel_fu]      = w_scan_ptr;
                w_last_idx                 = w_scan_ptr;
                w_grant_cnt                = w_grant_cnt + 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_dispatch_en  <= '0;
            rs_fu_assign    <= '0;
            fu_issue_valid  <= '0;
            fu_issue_rs_idx <= '0;
            r_stall_cycles  <= '0;
        end else begin
            rs_dispatch_en  <= flush ? '0 : w_grant_rs;
            rs_fu_assign    <= flush ? '0 : w_grant_assign;
            fu_issue_valid  <= flush ? '0 : w_grant_fu;
            fu_issue_rs_idx <= flush ? '0 : w_grant_src;
            if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int f = 0; f < NUM_OF_FU; f++) begin
            if (rst) begin
                r_busy_cnt[f] <= '0;
            end else if (!flush && w_grant_fu[f]) begin
                r_busy_cnt[f] <= BUSY_WIDTH'(FU_BUSY_CYCLES);
            end else if (r_busy_cnt[f] != '0) begin
                r_busy_cnt[f] <= r_busy_cnt[f] - 1'b1;
            end
        end
    end

    generate
        if (ARB_MODE == 1) begin : g_round_robin
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rr_ptr <= '0;
                end else if (!flush && w_any_grant) begin
                    r_rr_ptr <= (w_last_idx == RS_IDX_WIDTH'(NUM_OF_RS - 1)) ? '0
                                                                             : w_last_idx + 1'b1;
                end
            end
        end else begin : g_fixed_priority
            always_ff @(posedge clk) begin
                r_rr_ptr <= '0;
            end
        end
    endgenerate

    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_rs_fu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_fu_issue_arbiter
// Brief    : Directed and randomized checks of rs_fu_issue_arbiter against a
//            queue-based reference model (4 RS, 2 FU, busy 2, round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_fu_issue_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic [3:0]       rs_ready = '0;
    logic [1:0]       fu_ready = '0;
    logic [3:0]       rs_dispatch_en;
    logic [3:0][0:0]  rs_fu_assign;
    logic [1:0]       fu_issue_valid;
    logic [1:0][1:0]  fu_issue_rs_idx;
    logic [1:0]       fu_busy;
    logic [15:0]      stall_cycles;

    int total = 0;
    int bad   = 0;

    // Model state
    int          m_rr;
    int          m_busy [2];
    int          m_stall;
    logic [3:0]  m_disp;
    logic [31:0] exp_vec;
    logic [31:0] dut_vec;

    rs_fu_issue_arbiter #(
        .NUM_OF_RS      (4),
        .NUM_OF_FU      (2),
        .ISSUE_WIDTH    (2),
        .FU_BUSY_CYCLES (2),
        .ARB_MODE       (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .rs_ready        (rs_ready),
        .fu_ready        (fu_ready),
        .rs_dispatch_en  (rs_dispatch_en),
        .rs_fu_assign    (rs_fu_assign),
        .fu_issue_valid  (fu_issue_valid),
        .fu_issue_rs_idx (fu_issue_rs_idx),
        .fu_busy         (fu_busy),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    assign dut_vec = {rs_dispatch_en, rs_fu_assign, fu_issue_valid, fu_issue_rs_idx, fu_busy, stall_cycles};

    // Reference: build scan-order list of eligible entries and a list of free
    // FUs, then pair them front-to-front up to the issue limit of 2.
    task automatic model_eval(input logic [3:0] rr_in, input logic [1:0] fr, input logic fl, input logic rs);
        int q[$];
        int fq[$];
        int asg [4];
        int src [2];
        int nb  [2];
        int n, last, nelig, i, f;
        logic [3:0] nd, na, ns;
        logic [1:0] nv, nbusy;
        nd = '0; na = '0; ns = '0; nv = '0; nbusy = '0;
        foreach (asg[k]) asg[k] = 0;
        foreach (src[k]) src[k] = 0;
        if (rs) begin
            m_rr = 0; m_busy[0] = 0; m_busy[1] = 0; m_stall = 0; m_disp = '0;
            exp_vec = '0;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            i = (m_rr + k) % 4;
            if (rr_in[i] && !m_disp[i]) q.push_back(i);
        end
        for (int k = 0; k < 2; k++) if (fr[k] && m_busy[k] == 0) fq.push_back(k);
        nelig = q.size();
        n = 0;
        last = 0;
        if (!fl) begin
            while (q.size() > 0 && fq.size() > 0 && n < 2) begin
                i = q.pop_front();
                f = fq.pop_front();
                nd[i] = 1'b1; asg[i] = f; nv[f] = 1'b1; src[f] = i;
                n++;
                last = i;
            end
        end
        for (int k = 0; k < 2; k++) begin
            nb[k] = nv[k] ? 2 : ((m_busy[k] > 0) ? m_busy[k] - 1 : 0);
            m_busy[k] = nb[k];
            nbusy[k] = (nb[k] != 0);
        end
        if (!fl && nelig > 0 && n == 0 && m_stall < 65535) m_stall++;
        if (n > 0) m_rr = (last + 1) % 4;
        for (int k = 0; k < 4; k++) na[k] = asg[k][0];
        ns[1:0] = src[0][1:0];
        ns[3:2] = src[1][1:0];
        m_disp = nd;
        exp_vec = {nd, na, nv, ns, nbusy, m_stall[15:0]};
    endtask

    task automatic step(input logic [3:0] rr_in, input logic [1:0] fr, input logic fl, input logic rs);
        rs_ready = rr_in;
        fu_ready = fr;
        flush    = fl;
        rst      = rs;
        model_eval(rr_in, fr, fl, rs);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(4'($urandom), 2'($urandom), 1'($urandom), 1'b1);
            total++;
            if (dut_vec !== 32'h0) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h exp=00000000", c, dut_vec);
            end
        end
    endtask

    task automatic test_basic();
        step(4'b0000, 2'b00, 1'b0, 1'b1);
        step(4'b1111, 2'b11, 1'b0, 1'b0);
        total++;
        if ({rs_dispatch_en, rs_fu_assign, fu_busy} !== {4'b0011, 4'b0010, 2'b11}) begin
            bad++;
            $display("FAIL basic_first got=%b/%b/%b exp=0011/0010/11", rs_dispatch_en, rs_fu_assign, fu_busy);
        end
        for (int c = 0; c < 3; c++) step(4'b1100, 2'b11, 1'b0, 1'b0);
        total++;
        if ({rs_dispatch_en, rs_fu_assign, fu_issue_rs_idx} !== {4'b1100, 4'b1000, 4'b1110}) begin
            bad++;
            $display("FAIL basic_second got=%b/%b/%b exp=1100/1000/1110", rs_dispatch_en, rs_fu_assign, fu_issue_rs_idx);
        end
        total++;
        if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL basic_model got=%h exp=%h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_mask();
        step(4'b0000, 2'b00, 1'b0, 1'b1);
        step(4'b0001, 2'b11, 1'b0, 1'b0);
        total++;
        if (rs_dispatch_en !== 4'b0001) begin
            bad++;
            $display("FAIL mask_first got=%b exp=0001", rs_dispatch_en);
        end
        step(4'b0001, 2'b11, 1'b0, 1'b0);
        total++;
        if (rs_dispatch_en !== 4'b0000 || stall_cycles !== 16'd0) begin
            bad++;
            $display("FAIL mask_second got=%b stall=%0d exp=0000 stall=0", rs_dispatch_en, stall_cycles);
        end
    endtask

    task automatic test_wrap();
        step(4'b0000, 2'b00, 1'b0, 1'b1);
        step(4'b0100, 2'b11, 1'b0, 1'b0);
        step(4'b0000, 2'b11, 1'b0, 1'b0);
        step(4'b0000, 2'b11, 1'b0, 1'b0);
        step(4'b1001, 2'b11, 1'b0, 1'b0);
        total++;
        if ({rs_dispatch_en, rs_fu_assign, fu_issue_rs_idx} !== {4'b1001, 4'b0001, 4'b0011}) begin
            bad++;
            $display("FAIL wrap_grant got=%b/%b/%b exp=1001/0001/0011", rs_dispatch_en, rs_fu_assign, fu_issue_rs_idx);
        end
        step(4'b0000, 2'b11, 1'b0, 1'b0);
        step(4'b0000, 2'b11, 1'b0, 1'b0);
        step(4'b1111, 2'b11, 1'b0, 1'b0);
        total++;
        if (rs_dispatch_en !== 4'b0110) begin
            bad++;
            $display("FAIL wrap_rrptr got=%b exp=0110", rs_dispatch_en);
        end
    endtask

    task automatic test_flush();
        step(4'b0000, 2'b00, 1'b0, 1'b1);
        step(4'b1111, 2'b11, 1'b1, 1'b0);
        total++;
        if (rs_dispatch_en !== 4'b0000 || fu_issue_valid !== 2'b00 || stall_cycles !== 16'd0) begin
            bad++;
            $display("FAIL flush got=%b/%b stall=%0d exp=0000/00 stall=0", rs_dispatch_en, fu_issue_valid, stall_cycles);
        end
        step(4'b1111, 2'b11, 1'b0, 1'b0);
        total++;
        if (rs_dispatch_en !== 4'b0011) begin
            bad++;
            $display("FAIL flush_hold got=%b exp=0011", rs_dispatch_en);
        end
    endtask

    task automatic test_stall();
        step(4'b0000, 2'b00, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step(4'b0001, 2'b00, 1'b0, 1'b0);
            total++;
            if (rs_dispatch_en !== 4'b0000) begin
                bad++;
                $display("FAIL stall_nodisp cyc=%0d got=%b exp=0000", c, rs_dispatch_en);
            end
        end
        total++;
        if (stall_cycles !== 16'd5) begin
            bad++;
            $display("FAIL stall_count got=%0d exp=5", stall_cycles);
        end
    endtask

    task automatic test_random();
        step(4'b0000, 2'b00, 1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            step(4'($urandom), 2'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
            total++;
            if (dut_vec !== exp_vec) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_wrap();
        test_flush();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_fu_issue_arbiter.md
RS_FU_ISSUE_ARBITER -- requirements
Module: rs_fu_issue_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_OF_RS, default 8: number of reservation-station entries.
REQ-002 The block SHALL have parameter NUM_OF_FU, default 4: number of functional units.
REQ-003 The block SHALL have parameter ISSUE_WIDTH, default 2: maximum grants per cycle; effective limit is min(ISSUE_WIDTH, NUM_OF_RS, NUM_OF_FU).
REQ-004 The block SHALL have parameter FU_BUSY_CYCLES, default 0: cycles an FU stays blocked after a grant; 0 means fully pipelined.
REQ-005 The block SHALL have parameter ARB_MODE, default 1: 0 is fixed lowest-index RS priority, 1 is round-robin RS priority.
REQ-006 The block SHALL have derived widths FU_IDX_WIDTH = max(1, clog2(NUM_OF_FU)), RS_IDX_WIDTH = max(1, clog2(NUM_OF_RS)) and BUSY_WIDTH = max(1, clog2(FU_BUSY_CYCLES+1)).
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 flush  input  1  cancels grant computation in the current cycle.
REQ-010 rs_ready  input  NUM_OF_RS  entry i has its operands ready and requests issue.
REQ-011 fu_ready  input  NUM_OF_FU  FU f can accept an operation.
REQ-012 rs_dispatch_en  output  NUM_OF_RS  registered; entry i is dispatched this cycle.
REQ-013 rs_fu_assign  output  NUM_OF_RS x FU_IDX_WIDTH  registered; FU index for entry i, 0 when not dispatched.
REQ-014 fu_issue_valid  output  NUM_OF_FU  registered; FU f receives an operation this cycle.
REQ-015 fu_issue_rs_idx  output  NUM_OF_FU x RS_IDX_WIDTH  registered; source entry for FU f, 0 when not valid.
REQ-016 fu_busy  output  NUM_OF_FU  registered; busy_cnt[f] != 0.
REQ-017 stall_cycles  output  16  saturating count of cycles in which one or more eligible requests exist and zero grants are made.

Function
REQ-018 Grants SHALL be computed combinationally in cycle t and SHALL appear on all dispatch outputs at cycle t+1, a fixed latency of 1.
REQ-019 Entry i SHALL be eligible when rs_ready[i]=1 and rs_dispatch_en[i]=0; this masking prevents a double issue while the RS clears the entry.
REQ-020 FU f SHALL be available when fu_ready[f]=1 and busy_cnt[f]=0.
REQ-021 Entries SHALL be scanned starting at rr_ptr, ascending with wrap-around.
REQ-022 Each eligible entry in scan order SHALL take the lowest-index available FU not yet taken this cycle.
REQ-023 Scanning SHALL stop when the effective issue limit is reached or no FU remains.
REQ-024 Each FU SHALL receive at most one grant per cycle, and each entry SHALL receive at most one grant per cycle.
REQ-025 In ARB_MODE=1, rr_ptr SHALL update to (last granted index + 1) mod NUM_OF_RS in a cycle with one or more grants, and SHALL hold otherwise.
REQ-026 In ARB_MODE=0, rr_ptr SHALL stay 0.
REQ-027 On a grant to FU f, busy_cnt[f] SHALL load FU_BUSY_CYCLES at the next edge, and SHALL otherwise decrement toward 0, saturating at 0.
REQ-028 With FU_BUSY_CYCLES=N>0, an FU granted in cycle t SHALL next be grantable in cycle t+N+1.
REQ-029 When flush=1 in cycle t, no grants SHALL be made, all dispatch outputs SHALL be 0 at t+1, rr_ptr SHALL hold, busy counters SHALL continue decrementing, and stall_cycles SHALL not increment.
REQ-030 rs_fu_assign and fu_issue_rs_idx SHALL be consistent: rs_dispatch_en[i]=1 with rs_fu_assign[i]=f if and only if fu_issue_valid[f]=1 with fu_issue_rs_idx[f]=i.
REQ-031 stall_cycles SHALL increment by 1 per qualifying cycle and SHALL saturate at 16'hFFFF.

Reset
REQ-032 With rst=1 at a clock edge, all outputs, rr_ptr, every busy_cnt and stall_cycles SHALL be 0 after that edge.
REQ-033 rst SHALL take precedence over flush and over any grant.
REQ-034 A grant computed in the cycle rst is asserted SHALL be discarded.

Verification (NUM_OF_RS=4, NUM_OF_FU=2, ISSUE_WIDTH=2, FU_BUSY_CYCLES=2, ARB_MODE=1)
REQ-035 Reset test: rst=1 for 2 cycles with random inputs -> all outputs 0, stall_cycles=0.
REQ-036 Basic issue test: rs_ready=1111, fu_ready=11 at t -> at t+1 rs_dispatch_en=0011, rs_fu_assign[0]=0, rs_fu_assign[1]=1, fu_busy=11 -> with rs_ready=1100 held, at t+4 rs_dispatch_en=1100, rs_fu_assign[2]=0, rs_fu_assign[3]=1.
REQ-037 Mask test: rs_ready=0001 held at t and t+1, fu_ready=11 -> dispatch of entry 0 at t+1 only, rs_dispatch_en=0000 at t+2.
REQ-038 Wrap test: rr_ptr=3, rs_ready=1001, both FUs free -> entry 3 to FU 0 and entry 0 to FU 1, rr_ptr becomes 1.
REQ-039 Flush test: flush=1 with rs_ready=1111 and FUs free -> next-cycle rs_dispatch_en=0000, rr_ptr and stall_cycles unchanged.
REQ-040 Stall test: fu_ready=00, rs_ready=0001 for 5 cycles -> stall_cycles=5, no dispatch.
